// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles load-use hazards, taken branches, multi-cycle mult/div and dmem wait states.
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_LAT     = 32,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rw,
    input  logic             ex_mdu_start,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mdu_busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MDU_W  = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic {RUN, MDU} state_e;

    state_e            state_q, state_d;
    logic [MDU_W-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_q;

    logic dmem_wait;
    logic load_use;

    assign dmem_wait = mem_access && !dmem_ready;
    assign load_use  = ex_mem_read && (ex_rw != 5'd0) &&
                       ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path leaves one unassigned (no latches).
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        mdu_cnt_d   = mdu_cnt_q;

        // A dmem freeze must not stop the MDU countdown, so MDU timing sits outside the priority chain.
        if (state_q == MDU) begin
            if (mdu_cnt_q == '0) begin
                state_d = RUN;
            end else begin
                mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
            end
        end else if (!dmem_wait && !mem_branch_taken && ex_mdu_start) begin
            state_d   = MDU;
            mdu_cnt_d = MDU_W'(MDU_LAT - 2);
        end

        if (reset) begin
            // defaults already hold the reset-time output values
        end else if (dmem_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if ((state_q == RUN) && mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if ((state_q == MDU) || ex_mdu_start) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (dmem_wait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                              : wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            mdu_cnt_q  <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
            state_q    <= state_d;
            mdu_cnt_q  <= mdu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (dmem_wait && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT))) begin
                mem_err_q <= 1'b1;
            end
            if (!pc_write) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign mdu_busy     = !reset && (state_q == MDU);
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle priority cases,
// hand sequences for MDU occupancy, dmem timeout and asynchronous reset.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MDU_LAT     = 4;
    localparam int unsigned MEM_TIMEOUT = 255;
    localparam int unsigned CNT_W       = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rw;
    logic             id_uses_rt, ex_mem_read, ex_mdu_start;
    logic             mem_branch_taken, mem_access, dmem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic             mdu_busy, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int stall_exp = 0;

    pipe_hazard_ctrl #(
        .MDU_LAT    (MDU_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rw           (ex_rw),
        .ex_mdu_start    (ex_mdu_start),
        .mem_branch_taken(mem_branch_taken),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .mdu_busy        (mdu_busy),
        .mem_err         (mem_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // {pc, ifid, idex, exmem, ifid_flush, idex_flush, exmem_flush}
    logic [6:0] outs;
    assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                   ifid_flush, idex_flush, exmem_flush};

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] rw;
        logic       mdu_start;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rw = 5'd0; ex_mdu_start = 1'b0;
        mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    // Entered at posedge+1: settle, compare combinational outputs, advance one clock.
    task automatic cyc(input string name, input logic [6:0] exp_outs, input logic exp_busy);
        #2;
        check({name, " outs"}, 32'(outs), 32'(exp_outs));
        check({name, " busy"}, 32'(mdu_busy), 32'(exp_busy));
        @(posedge clk);
        #1;
        if (!exp_outs[6]) stall_exp++;
    endtask

    initial begin
        int s0;

        vecs[0]  = '{"idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111000};
        vecs[1]  = '{"lu_rs",         5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0011010};
        vecs[2]  = '{"lu_r0",         5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111000};
        vecs[3]  = '{"lu_rt",         5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0011010};
        vecs[4]  = '{"rt_unused",     5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111000};
        vecs[5]  = '{"no_load",       5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111000};
        vecs[6]  = '{"branch",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1111111};
        vecs[7]  = '{"branch_lu",     5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1111111};
        vecs[8]  = '{"branch_mdu",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1111111};
        vecs[9]  = '{"dmem_wait",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000000};
        vecs[10] = '{"wait_branch",   5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0000000};
        vecs[11] = '{"dmem_ready",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111000};
        vecs[12] = '{"no_access",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111000};

        // Reset with hazardous inputs present: outputs must still show the reset pattern.
        drive_idle();
        reset = 1'b1;
        ex_mem_read = 1'b1; ex_rw = 5'd5; id_rs = 5'd5;
        mem_access = 1'b1; dmem_ready = 1'b0;
        #2;
        check("reset outs", 32'(outs), 32'(7'b1111000));
        check("reset busy", 32'(mdu_busy), 32'd0);
        check("reset mem_err", 32'(mem_err), 32'd0);
        check("reset stall", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            ex_mem_read = vecs[i].mem_read; ex_rw = vecs[i].rw;
            ex_mdu_start = vecs[i].mdu_start; mem_branch_taken = vecs[i].br;
            mem_access = vecs[i].acc; dmem_ready = vecs[i].rdy;
            cyc(vecs[i].name, vecs[i].exp, 1'b0);
            check({vecs[i].name, " stall_cnt"}, 32'(stall_cycles), 32'(stall_exp));
        end

        // MDU start pulse: four stall cycles, three in MDU, branch ignored while busy.
        drive_idle();
        s0 = stall_exp;
        ex_mdu_start = 1'b1;
        cyc("mdu_start", 7'b0001001, 1'b0);
        ex_mdu_start = 1'b0;
        cyc("mdu_c1", 7'b0001001, 1'b1);
        mem_branch_taken = 1'b1;
        cyc("mdu_c2_br", 7'b0001001, 1'b1);
        mem_branch_taken = 1'b0;
        cyc("mdu_c3", 7'b0001001, 1'b1);
        cyc("mdu_done", 7'b1111000, 1'b0);
        check("mdu stall+4", 32'(stall_cycles), 32'(s0 + 4));

        // Dmem wait during MDU: full freeze but MDU still ends on schedule.
        s0 = stall_exp;
        ex_mdu_start = 1'b1;
        cyc("mduw_start", 7'b0001001, 1'b0);
        ex_mdu_start = 1'b0;
        mem_access = 1'b1; dmem_ready = 1'b0;
        cyc("mduw_w1", 7'b0000000, 1'b1);
        cyc("mduw_w2", 7'b0000000, 1'b1);
        cyc("mduw_w3", 7'b0000000, 1'b1);
        drive_idle();
        cyc("mduw_done", 7'b1111000, 1'b0);
        check("mduw stall+4", 32'(stall_cycles), 32'(s0 + 4));

        // Dmem timeout: mem_err after MEM_TIMEOUT wait cycles, sticky afterwards.
        mem_access = 1'b1; dmem_ready = 1'b0;
        repeat (MEM_TIMEOUT - 1) begin
            @(posedge clk);
            #1;
            stall_exp++;
        end
        check("mem_err before timeout", 32'(mem_err), 32'd0);
        cyc("timeout_last_wait", 7'b0000000, 1'b0);
        check("mem_err at timeout", 32'(mem_err), 32'd1);
        dmem_ready = 1'b1;
        cyc("timeout_ready", 7'b1111000, 1'b0);
        drive_idle();
        cyc("timeout_idle", 7'b1111000, 1'b0);
        check("mem_err sticky", 32'(mem_err), 32'd1);
        check("timeout stall_cnt", 32'(stall_cycles), 32'(stall_exp));

        // Async reset between edges while in MDU.
        ex_mdu_start = 1'b1;
        cyc("rst_mdu_start", 7'b0001001, 1'b0);
        ex_mdu_start = 1'b0;
        #2;
        check("pre_rst busy", 32'(mdu_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst outs", 32'(outs), 32'(7'b1111000));
        check("midrst busy", 32'(mdu_busy), 32'd0);
        check("midrst stall", 32'(stall_cycles), 32'd0);
        check("midrst mem_err", 32'(mem_err), 32'd0);
        stall_exp = 0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc("post_rst_idle", 7'b1111000, 1'b0);
        check("post_rst stall", 32'(stall_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It drives the write enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers. It covers load-use hazards, taken branches resolved in MEM, multi-cycle mult/div occupancy in EX, and data-memory wait states. State updates on posedge clk so outputs are settled before the pipeline registers latch on negedge clk.

Parameters:
MDU_LAT, 32, total stall cycles for one mult/div op (>=2)
MEM_TIMEOUT, 255, consecutive dmem wait cycles before mem_err sets
CNT_W, 16, width of the stall_cycles performance counter

Ports:
clk  in  1  system clock; state updates on rising edge
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rw  in  5  destination register of the instruction in EX
ex_mdu_start  in  1  mult/div in EX requests start
mem_branch_taken  in  1  branch in MEM is taken (branch & zero)
mem_access  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_write  out  1  ID/EX load enable
exmem_write  out  1  EX/MEM load enable
ifid_flush  out  1  IF/ID loads zero
idex_flush  out  1  ID/EX loads zero (bubble)
exmem_flush  out  1  EX/MEM loads zero (bubble)
mdu_busy  out  1  FSM in MDU state
mem_err  out  1  sticky dmem timeout flag
stall_cycles  out  CNT_W  count of cycles with pc_write=0

Behaviour:
- FSM states: RUN, MDU. Registers: state, mdu_cnt, wait_cnt, mem_err, stall_cycles.
- Reset (async, while high): state=RUN, mdu_cnt=0, wait_cnt=0, mem_err=0, stall_cycles=0.
  - Outputs during reset: all *_write=1, all *_flush=0, mdu_busy=0.
- Outputs are combinational from state and current inputs, evaluated in strict priority order:
  1. Dmem wait (mem_access & !dmem_ready, any state): all four *_write=0, all flushes=0 (full freeze). In MDU, mdu_cnt still decrements.
  2. Branch (RUN, mem_branch_taken): pc_write=1, ifid_flush=idex_flush=exmem_flush=1, all other writes=1.
     - A pending load-use or mdu start in the same cycle is discarded, because those instructions are flushed.
  3. MDU state: pc_write=ifid_write=idex_write=0, exmem_write=1, exmem_flush=1.
  4. MDU start (RUN, ex_mdu_start): same outputs as item 3 for this cycle. Next state=MDU, mdu_cnt=MDU_LAT-2.
  5. Load-use (RUN, ex_mem_read & ex_rw!=0 & (ex_rw==id_rs | (id_uses_rt & ex_rw==id_rt))): pc_write=ifid_write=0, idex_flush=1, exmem_write=1. The hazard resolves itself one cycle later.
  6. Otherwise: all writes=1, all flushes=0.
- MDU state timing:
  - Each posedge decrements mdu_cnt.
  - When mdu_cnt==0 at a posedge, next state=RUN.
  - Total stall is exactly MDU_LAT cycles, counting the start cycle.
  - mem_branch_taken is ignored in MDU, since MEM holds a bubble.
- wait_cnt:
  - Increments (saturating) each cycle that dmem wait holds.
  - Clears on any cycle without a wait.
  - mem_err sets when wait_cnt reaches MEM_TIMEOUT and stays set until reset.
  - mem_err has no effect on stalling; the freeze continues.
- stall_cycles increments at each posedge with pc_write=0 and wraps modulo 2^CNT_W.
- A flush together with write=1 loads zero. Flush outputs are never asserted while the corresponding write=0.
- Reset mid-MDU or mid-wait aborts immediately to the reset values.

Test Plan:
- Load-use: ex_mem_read=1, ex_rw=5, id_rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; with ex_rw=0 -> no stall.
- Branch: mem_branch_taken=1 in RUN with a load-use present -> ifid/idex/exmem_flush=1, pc_write=1, stall_cycles unchanged.
- MDU with MDU_LAT=4: ex_mdu_start pulse -> pc_write=0 for exactly 4 cycles, mdu_busy=1 for 3 cycles, then RUN; stall_cycles +4.
- Dmem wait 3 cycles during MDU -> full freeze for 3 cycles, MDU still ends MDU_LAT cycles after start; dmem wait held MEM_TIMEOUT cycles -> mem_err=1 and stays 1 after dmem_ready.
- Async reset asserted mid-MDU between clock edges -> outputs take reset values immediately, state=RUN, stall_cycles=0.
